display_scan_controller: RTL

//  Sequencer for the 4-digit multiplexed 7-segment display datapath. Generates the 2-bit

---
 rtl/display_scan_controller.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/display_scan_controller.sv
// -----------------------------------------------------------------------------
// display_scan_controller
//
// Purpose:
//   Sequencer for a 4-digit multiplexed 7-segment display. It produces the
//   2-bit digit select (contador) for the downstream digit demux and segment
//   mux. Between digits it forces a short blank gap so the previous digit's
//   segments never ghost onto the next digit. Masked digits are skipped, and a
//   one-cycle pulse marks the point where the scan wraps back to the start of
//   a frame.
//
// Parameters:
//   SCAN_DIV      clk cycles each digit is shown (>= 1)
//   BLANK_CYCLES  clk cycles of forced blank between digits (>= 0)
//   BLINK_FRAMES  frames per blink half-period (>= 1), only with
//                 DISPLAY_BLINK_EN
//
// Optional feature macro:
//   DISPLAY_BLINK_EN  adds the blink_mask port, a frame counter and a blink
//                     phase. Masked digits are blanked during SHOW while the
//                     phase is hidden. Without the macro, blank depends on
//                     the FSM state alone.
//
// Ports:
//   clk         in   1  system clock
//   reset       in   1  synchronous, active-high reset
//   enable      in   1  scan enable; low turns the display off
//   skip_mask   in   4  bit k = 1: digit k is not scanned
//   blink_mask  in   4  bit k = 1: digit k blinks (DISPLAY_BLINK_EN only)
//   contador    out  2  digit select; value k selects digit k
//   blank       out  1  1 = force all digit enables off downstream
//   frame_done  out  1  one-cycle pulse when the scan wraps to a new frame
//
// The FSM state is held in the named register 'state' (type state_t) so it
// can be observed hierarchically.
// -----------------------------------------------------------------------------
module display_scan_controller #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] skip_mask,
`ifdef DISPLAY_BLINK_EN
    input  logic [3:0] blink_mask,
`endif
    output logic [1:0] contador,
    output logic       blank,
    output logic       frame_done
);

    localparam int PW = $clog2(SCAN_DIV) + 1;
    localparam int BW = $clog2(BLANK_CYCLES + 1) + 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [1:0]      contador_d;
    logic            blank_d;
    logic            frame_done_d;
    logic [PW-1:0]   prescaler, prescaler_d;
    logic [BW-1:0]   blank_cnt, blank_cnt_d;
    logic            wrap;

`ifdef DISPLAY_BLINK_EN
    localparam int FW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic            hidden, hidden_d;
    logic [FW-1:0]   frame_cnt, frame_cnt_d;
`endif

    // Lowest digit whose skip bit is clear. Only meaningful when the mask is
    // not all ones; the caller guarantees that.
    function automatic logic [1:0] lowest_unmasked(input logic [3:0] mask);
        logic [1:0] low;
        low = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!mask[i]) begin
                low = 2'(i);
            end
        end
        return low;
    endfunction

    // Next unmasked digit after cur, searching upward with wrap-around. The
    // loop runs from the farthest offset down so the nearest hit is the last
    // assignment. With no other unmasked digit, cur is kept.
    function automatic logic [1:0] next_unmasked(input logic [1:0] cur,
                                                 input logic [3:0] mask);
        logic [1:0] nxt;
        logic [1:0] cand;
        nxt = cur;
        for (int i = 3; i >= 1; i--) begin
            cand = cur + 2'(i);
            if (!mask[cand]) begin
                nxt = cand;
            end
        end
        return nxt;
    endfunction

    always_comb begin
        state_d      = state;
        contador_d   = contador;
        prescaler_d  = prescaler;
        blank_cnt_d  = blank_cnt;
        wrap         = 1'b0;
        frame_done_d = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            contador_d  = 2'd0;
            prescaler_d = '0;
            blank_cnt_d = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (skip_mask != 4'b1111) begin
                        state_d     = SHOW;
                        contador_d  = lowest_unmasked(skip_mask);
                        prescaler_d = '0;
                    end
                end
                SHOW: begin
                    if (prescaler == PRE_LAST) begin
                        prescaler_d = '0;
                        if (&skip_mask) begin
                            // Every digit masked: finish this dwell and park.
                            state_d    = IDLE;
                            contador_d = 2'd0;
                        end else begin
                            contador_d   = next_unmasked(contador, skip_mask);
                            // new <= old also covers the single-digit case,
                            // where every advance starts a new frame.
                            wrap         = (contador_d <= contador);
                            frame_done_d = wrap;
                            blank_cnt_d  = '0;
                            state_d      = (BLANK_CYCLES > 0) ? BLANK : SHOW;
                        end
                    end else begin
                        prescaler_d = prescaler + PW'(1);
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state_d     = SHOW;
                        blank_cnt_d = '0;
                        prescaler_d = '0;
                    end else begin
                        blank_cnt_d = blank_cnt + BW'(1);
                    end
                end
                default: begin
                    state_d     = IDLE;
                    contador_d  = 2'd0;
                    prescaler_d = '0;
                    blank_cnt_d = '0;
                end
            endcase
        end

`ifdef DISPLAY_BLINK_EN
        hidden_d    = hidden;
        frame_cnt_d = frame_cnt;
        if (!enable) begin
            hidden_d    = 1'b0;
            frame_cnt_d = '0;
        end else if (wrap) begin
            if (frame_cnt == FRAME_LAST) begin
                frame_cnt_d = '0;
                hidden_d    = ~hidden;
            end else begin
                frame_cnt_d = frame_cnt + FW'(1);
            end
        end
        // blank is registered, so it is derived from next-state values so it
        // changes on the same edge as contador.
        blank_d = (state_d != SHOW) || (hidden_d && blink_mask[contador_d]);
`else
        blank_d = (state_d != SHOW);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            contador   <= 2'd0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
            prescaler  <= '0;
            blank_cnt  <= '0;
`ifdef DISPLAY_BLINK_EN
            hidden     <= 1'b0;
            frame_cnt  <= '0;
`endif
        end else begin
            state      <= state_d;
            contador   <= contador_d;
            blank      <= blank_d;
            frame_done <= frame_done_d;
            prescaler  <= prescaler_d;
            blank_cnt  <= blank_cnt_d;
`ifdef DISPLAY_BLINK_EN
            hidden     <= hidden_d;
            frame_cnt  <= frame_cnt_d;
`endif
        end
    end

endmodule
